// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: control word layout, field positions and the bubble word.
package pipeline_pkg;

  localparam int CTRL_W = 39;

  localparam int AF_MSB     = 38;
  localparam int AF_LSB     = 35;
  localparam int I_BIT      = 34;
  localparam int ALU_MUX    = 33;
  localparam int SHIFT_MSB  = 32;
  localparam int SHIFT_LSB  = 30;
  localparam int CAD_MSB    = 29;
  localparam int CAD_LSB    = 25;
  localparam int GP_WE_BIT  = 24;
  localparam int GP_SEL_MSB = 23;
  localparam int GP_SEL_LSB = 22;
  localparam int BF_MSB     = 21;
  localparam int BF_LSB     = 18;
  localparam int PC_SEL_MSB = 17;
  localparam int PC_SEL_LSB = 16;
  localparam int WREN_BIT   = 15;
  localparam int RD_MSB     = 14;
  localparam int RD_LSB     = 10;
  localparam int RS_MSB     = 9;
  localparam int RS_LSB     = 5;
  localparam int RT_MSB     = 4;
  localparam int RT_LSB     = 0;

  localparam logic [1:0]        GP_SEL_MEM  = 2'b01;
  localparam logic [CTRL_W-1:0] CTRL_BUBBLE = '0;

  typedef struct packed {
    logic [3:0] af;
    logic       i;
    logic       alu_mux_sel;
    logic [2:0] shift_type;
    logic [4:0] cad;
    logic       gp_we;
    logic [1:0] gp_mux_sel;
    logic [3:0] bf;
    logic [1:0] pc_mux_select;
    logic       mem_wren;
    logic [4:0] rd;
    logic [4:0] rs;
    logic [4:0] rt;
  } ctrl_t;

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard check between the instruction in EX and the one in decode.
module load_use_detect
  import pipeline_pkg::*;
(
  input  logic [CTRL_W-1:0] ex_ctrl,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic              valid_in,
  output logic              load_use
);

  ctrl_t ex;
  ctrl_t id;
  logic  ex_is_load;
  logic  reads_rt;
  logic  unused_bits;

  assign ex = ctrl_t'(ex_ctrl);
  assign id = ctrl_t'(id_ctrl);

  // EX valid is implied: an invalid EX slot always carries the all-zero word, so gp_we is 0.
  assign ex_is_load = ex.gp_we && (ex.gp_mux_sel == GP_SEL_MEM) && (ex.cad != 5'd0);
  assign reads_rt   = !id.i || id.mem_wren;

  assign load_use = valid_in && ex_is_load &&
                    ((ex.cad == id.rs) || (reads_rt && (ex.cad == id.rt)));

  assign unused_bits = ^{ex.af, ex.i, ex.alu_mux_sel, ex.shift_type, ex.bf, ex.pc_mux_select,
                         ex.mem_wren, ex.rd, ex.rs, ex.rt, id.af, id.alu_mux_sel,
                         id.shift_type, id.cad, id.gp_we, id.gp_mux_sel, id.bf,
                         id.pc_mux_select, id.rd};

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, flush, hold and a bubble counter.
module id_ex_stage
  import pipeline_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CTRL_W-1:0] ctrl_in,
  input  logic              valid_in,
  input  logic [XLEN-1:0]   pc_in,
  input  logic [XLEN-1:0]   a_in,
  input  logic [XLEN-1:0]   b_in,
  input  logic              flush,
  input  logic              hold,
  output logic [CTRL_W-1:0] ctrl_out,
  output logic              valid_out,
  output logic [XLEN-1:0]   pc_out,
  output logic [XLEN-1:0]   a_out,
  output logic [XLEN-1:0]   b_out,
  output logic              stall_out,
  output logic [CNT_W-1:0]  bubble_cnt
);

  logic load_use;

  load_use_detect u_detect (
    .ex_ctrl  (ctrl_out),
    .id_ctrl  (ctrl_in),
    .valid_in (valid_in),
    .load_use (load_use)
  );

  assign stall_out = load_use && !flush && !hold;

  // Priority: reset, flush, hold, load-use bubble, normal advance.
  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_out   <= CTRL_BUBBLE;
      valid_out  <= 1'b0;
      pc_out     <= '0;
      a_out      <= '0;
      b_out      <= '0;
      bubble_cnt <= '0;
    end else if (flush) begin
      ctrl_out  <= CTRL_BUBBLE;
      valid_out <= 1'b0;
    end else if (hold) begin
      ctrl_out  <= ctrl_out;
      valid_out <= valid_out;
    end else if (load_use) begin
      ctrl_out  <= CTRL_BUBBLE;
      valid_out <= 1'b0;
      if (bubble_cnt != {CNT_W{1'b1}})
        bubble_cnt <= bubble_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      ctrl_out  <= valid_in ? ctrl_in : CTRL_BUBBLE;
      valid_out <= valid_in;
      pc_out    <= pc_in;
      a_out     <= a_in;
      b_out     <= b_in;
    end
  end

endmodule
